program_sequencer: RTL and testbench

PROGRAM_SEQUENCER -- requirements
Module: program_sequencer

---
 rtl/program_sequencer_pkg.sv | 20 ++
 rtl/program_sequencer_if.sv | 21 ++
 rtl/seq_watchdog.sv | 25 ++
 rtl/program_sequencer.sv | 92 +++++++++
 tb/tb_program_sequencer.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/program_sequencer_pkg.sv
// Shared types and defaults for the program sequencer slice.
package program_sequencer_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_LOAD,
      S_ISSUE,
      S_WAIT_DONE,
      S_HALT
   } state_t;

   localparam logic [15:0] DEFAULT_HALT_WORD = 16'hFFFF;
   localparam int          DEFAULT_TIMEOUT   = 255;

   function automatic logic is_busy(input state_t s);
      return !(s == S_IDLE || s == S_HALT);
   endfunction

endpackage

// File: rtl/program_sequencer_if.sv
// Instruction-memory bus and control-unit handshake between sequencer and its peers.
interface program_sequencer_if #(
   parameter int ADDR_W = 8
);
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_rd;
   logic [15:0]       mem_data;
   logic [15:0]       instruction;
   logic              run;
   logic              done;

   modport master (
      output mem_addr, mem_rd, instruction, run,
      input  mem_data, done
   );

   modport slave (
      input  mem_addr, mem_rd, instruction, run,
      output mem_data, done
   );
endinterface

// File: rtl/seq_watchdog.sv
// Per-instruction done watchdog: counts enabled cycles, flags the terminal-count cycle.
module seq_watchdog #(
   parameter int TIMEOUT = 255
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);
   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   logic [CW-1:0] count;

   // NOTE: sequential state is written with non-blocking assignments only.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                   count <= '0;
      else if (clear)              count <= '0;
      else if (enable && !expired) count <= count + CW'(1);
   end

   // High during the TIMEOUT-th enabled cycle, so the caller acts on that edge.
   assign expired = enable && (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/program_sequencer.sv
// Fetches 16-bit instructions, issues each to the control unit and waits for done.
module program_sequencer
   import program_sequencer_pkg::*;
#(
   parameter int          ADDR_W    = 8,
   parameter int          TIMEOUT   = DEFAULT_TIMEOUT,
   parameter logic [15:0] HALT_WORD = DEFAULT_HALT_WORD
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   program_sequencer_if.master bus,
   output logic [ADDR_W-1:0]   pc,
   output logic                busy,
   output logic                halted,
   output logic                timeout_err
);

   state_t            state, state_n;
   logic [ADDR_W-1:0] pc_n;
   logic [15:0]       instr_n;
   logic              err_n;
   logic              wd_expired;

   seq_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
      .clk     (clk),
      .reset   (reset),
      .clear   (state == S_ISSUE),
      .enable  (state == S_WAIT_DONE),
      .expired (wd_expired)
   );

   assign bus.mem_addr = pc;

   // NOTE: every variable gets a default first, so no path can infer a latch.
   always_comb begin
      state_n = state;
      pc_n    = pc;
      instr_n = bus.instruction;
      err_n   = timeout_err;
      case (state)
         S_IDLE, S_HALT: begin
            if (start) begin
               state_n = S_FETCH;
               pc_n    = '0;
               err_n   = 1'b0;
            end
         end
         S_FETCH: state_n = S_LOAD;
         S_LOAD: begin
            instr_n = bus.mem_data;
            state_n = (bus.mem_data == HALT_WORD) ? S_HALT : S_ISSUE;
         end
         S_ISSUE: state_n = S_WAIT_DONE;
         S_WAIT_DONE: begin
            // done beats a simultaneous watchdog expiry
            if (bus.done) begin
               state_n = S_FETCH;
               pc_n    = pc + ADDR_W'(1);
            end else if (wd_expired) begin
               state_n = S_HALT;
               err_n   = 1'b1;
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   // Outputs are registered from the next state so they line up with it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state           <= S_IDLE;
         pc              <= '0;
         bus.instruction <= '0;
         bus.run         <= 1'b0;
         bus.mem_rd      <= 1'b0;
         busy            <= 1'b0;
         halted          <= 1'b0;
         timeout_err     <= 1'b0;
      end else begin
         state           <= state_n;
         pc              <= pc_n;
         bus.instruction <= instr_n;
         bus.run         <= (state_n == S_ISSUE) || (state_n == S_WAIT_DONE);
         bus.mem_rd      <= (state_n == S_FETCH);
         busy            <= is_busy(state_n);
         halted          <= (state_n == S_HALT);
         timeout_err     <= err_n;
      end
   end

endmodule

// File: tb/tb_program_sequencer.sv
// Directed bench for program_sequencer with instruction and fetch-address scoreboards.
module tb_program_sequencer;

   localparam int AW_A = 8;
   localparam int AW_B = 2;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic start_a = 1'b0;
   logic start_b = 1'b0;

   logic [AW_A-1:0] pc_a;
   logic            busy_a, halted_a, err_a;
   logic [AW_B-1:0] pc_b;
   logic            busy_b, halted_b, err_b;

   int tests = 0;
   int fails = 0;

   logic [15:0]     mem_a [256];
   logic [15:0]     mem_b [4];
   logic [15:0]     exp_q [$];
   logic [AW_B-1:0] pc_q  [$];
   logic [AW_A-1:0] exp_pc_a;

   bit   mon_b = 1'b0;
   int   run_cnt_b = 0;
   logic done_prev_b = 1'b0;

   always #5 clk = ~clk;

   program_sequencer_if #(.ADDR_W(AW_A)) ifa ();
   program_sequencer_if #(.ADDR_W(AW_B)) ifb ();

   program_sequencer #(.ADDR_W(AW_A), .TIMEOUT(255), .HALT_WORD(16'hFFFF)) dut_a (
      .clk(clk), .reset(reset), .start(start_a), .bus(ifa.master),
      .pc(pc_a), .busy(busy_a), .halted(halted_a), .timeout_err(err_a)
   );

   program_sequencer #(.ADDR_W(AW_B), .TIMEOUT(4), .HALT_WORD(16'hFFFF)) dut_b (
      .clk(clk), .reset(reset), .start(start_b), .bus(ifb.master),
      .pc(pc_b), .busy(busy_b), .halted(halted_b), .timeout_err(err_b)
   );

   // Synchronous instruction memories: data valid the cycle after mem_rd.
   always @(posedge clk) if (ifa.mem_rd) ifa.mem_data <= mem_a[ifa.mem_addr];
   always @(posedge clk) if (ifb.mem_rd) ifb.mem_data <= mem_b[ifb.mem_addr];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Fetch-address scoreboard and auto done responder for the narrow instance.
   always @(negedge clk) begin
      if (mon_b) begin
         if (done_prev_b) check("run_after_done", ifb.run, 1'b0);
         if (ifb.mem_rd && pc_q.size() > 0) check("wrap_pc", ifb.mem_addr, pc_q.pop_front());
         run_cnt_b   = ifb.run ? run_cnt_b + 1 : 0;
         ifb.done    = (run_cnt_b == 2);
         done_prev_b = ifb.done;
      end else begin
         ifb.done    = 1'b0;
         done_prev_b = 1'b0;
         run_cnt_b   = 0;
      end
   end

   task automatic pulse_a;
      @(negedge clk); start_a = 1'b1;
      @(negedge clk); start_a = 1'b0;
   endtask

   task automatic wait_run_a;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (ifa.run) break;
      end
      check("run_rise", ifa.run, 1'b1);
   endtask

   task automatic wait_halt_a;
      for (int i = 0; i < 20; i++) begin
         if (halted_a) break;
         @(negedge clk);
      end
      check("halt_reached", halted_a, 1'b1);
   endtask

   task automatic issue_check_a(output logic [15:0] exp);
      wait_run_a();
      exp = exp_q.pop_front();
      check("issue_instr", ifa.instruction, exp);
   endtask

   // Issue one instruction and return done on the done_at-th cycle after run rises.
   task automatic serve_a(input int done_at);
      logic [15:0] exp;
      issue_check_a(exp);
      for (int k = 1; k < done_at; k++) begin
         @(negedge clk);
         check("run_hold", ifa.run, 1'b1);
         check("instr_hold", ifa.instruction, exp);
      end
      @(negedge clk);
      check("run_before_done", ifa.run, 1'b1);
      ifa.done = 1'b1;
      @(negedge clk);
      ifa.done = 1'b0;
      check("run_drop", ifa.run, 1'b0);
      exp_pc_a = exp_pc_a + 8'd1;
      check("pc_inc", pc_a, exp_pc_a);
      check("no_err", err_a, 1'b0);
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

   initial begin
      logic [15:0] w;
      ifa.done = 1'b0;
      foreach (mem_a[i]) mem_a[i] = 16'h0000;

      // Reset state and quiet after release
      repeat (2) @(negedge clk);
      check("rst_run", ifa.run, 1'b0);
      check("rst_mem_rd", ifa.mem_rd, 1'b0);
      check("rst_pc", pc_a, 0);
      check("rst_instr", ifa.instruction, 16'h0000);
      check("rst_busy", busy_a, 1'b0);
      check("rst_halted", halted_a, 1'b0);
      check("rst_err", err_a, 1'b0);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      check("idle_no_fetch", ifa.mem_rd, 1'b0);
      check("idle_busy", busy_a, 1'b0);

      // Two-instruction program ending in the halt word
      mem_a[0] = 16'h2004; mem_a[1] = 16'h4008; mem_a[2] = 16'hFFFF;
      exp_q.push_back(16'h2004); exp_q.push_back(16'h4008);
      exp_pc_a = '0;
      pulse_a();
      check("start_fetch", ifa.mem_rd, 1'b1);
      check("start_addr", ifa.mem_addr, 0);
      check("start_busy", busy_a, 1'b1);
      serve_a(2);
      serve_a(2);
      wait_halt_a();
      check("prog_pc", pc_a, 2);
      check("prog_run", ifa.run, 1'b0);
      check("prog_busy", busy_a, 1'b0);
      check("prog_queue", exp_q.size(), 0);

      // Done withheld: watchdog fires 255 cycles after WAIT_DONE entry
      mem_a[0] = 16'h1111;
      exp_q.push_back(16'h1111);
      pulse_a();
      issue_check_a(w);
      for (int k = 1; k <= 255; k++) begin
         @(negedge clk);
         if (k == 10) start_a = 1'b1;
         if (k == 11) start_a = 1'b0;
         if (k == 12) begin
            check("start_ignored_pc", pc_a, 0);
            check("start_ignored_instr", ifa.instruction, 16'h1111);
            check("start_ignored_run", ifa.run, 1'b1);
         end
      end
      check("pre_timeout_err", err_a, 1'b0);
      check("pre_timeout_run", ifa.run, 1'b1);
      @(negedge clk);
      check("timeout_err", err_a, 1'b1);
      check("timeout_run", ifa.run, 1'b0);
      check("timeout_halted", halted_a, 1'b1);
      check("timeout_pc", pc_a, 0);

      // Done in the terminal-count cycle wins
      mem_a[0] = 16'h2222; mem_a[1] = 16'hFFFF;
      exp_q.push_back(16'h2222);
      exp_pc_a = '0;
      pulse_a();
      check("err_clear_on_start", err_a, 1'b0);
      serve_a(255);
      wait_halt_a();
      check("tc_pc", pc_a, 1);
      check("tc_err", err_a, 1'b0);

      // done while halted is ignored
      ifa.done = 1'b1;
      repeat (3) @(negedge clk);
      ifa.done = 1'b0;
      check("done_halt_halted", halted_a, 1'b1);
      check("done_halt_pc", pc_a, 1);
      check("done_halt_run", ifa.run, 1'b0);

      // Reset during WAIT_DONE at pc=5
      for (int i = 0; i < 6; i++) mem_a[i] = 16'h3000 + 16'(i);
      mem_a[6] = 16'hFFFF;
      for (int i = 0; i < 6; i++) exp_q.push_back(16'h3000 + 16'(i));
      exp_pc_a = '0;
      pulse_a();
      repeat (5) serve_a(1);
      issue_check_a(w);
      check("pc_at_5", pc_a, 5);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("mid_rst_run", ifa.run, 1'b0);
      check("mid_rst_pc", pc_a, 0);
      check("mid_rst_instr", ifa.instruction, 16'h0000);
      check("mid_rst_busy", busy_a, 1'b0);
      check("mid_rst_mem_rd", ifa.mem_rd, 1'b0);
      @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      check("post_rst_idle", busy_a, 1'b0);
      exp_q.push_back(16'h3000);
      pulse_a();
      check("refetch_rd", ifa.mem_rd, 1'b1);
      check("refetch_addr", ifa.mem_addr, 0);
      issue_check_a(w);
      @(negedge clk); reset = 1'b1;
      @(negedge clk); reset = 1'b0;

      // Narrow pc wraps 3 -> 0 with no flag
      for (int i = 0; i < 4; i++) mem_b[i] = 16'h5000 + 16'(i);
      pc_q.push_back(2'd0); pc_q.push_back(2'd1); pc_q.push_back(2'd2);
      pc_q.push_back(2'd3); pc_q.push_back(2'd0); pc_q.push_back(2'd1);
      mon_b = 1'b1;
      @(negedge clk); start_b = 1'b1;
      @(negedge clk); start_b = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (pc_q.size() == 0) break;
         @(negedge clk);
      end
      mon_b = 1'b0;
      check("wrap_seq_done", pc_q.size(), 0);
      check("wrap_no_err", err_b, 1'b0);
      check("wrap_not_halted", halted_b, 1'b0);
      @(negedge clk); reset = 1'b1;
      @(negedge clk); reset = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
